// File: rtl/tsip_packet_rx_pkg.sv
// TSIP framing constants, error codes and FSM state types
// shared by the packet receiver and its de-stuffer.
package tsip_pkg;

    localparam logic [7:0] TSIP_DLE = 8'h10;
    localparam logic [7:0] TSIP_ETX = 8'h03;

    localparam logic [7:0] TSIP_ID_8E  = 8'h8E;
    localparam logic [7:0] TSIP_ID_8F  = 8'h8F;
    localparam logic [7:0] TSIP_SUB_A2 = 8'hA2;
    localparam logic [7:0] TSIP_SUB_A5 = 8'hA5;
    localparam logic [7:0] TSIP_SUB_AB = 8'hAB;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_LEN     = 2'd3;

    typedef enum logic [1:0] {
        DS_HUNT,
        DS_START,
        DS_DATA,
        DS_DLE
    } ds_state_e;

    typedef enum logic [2:0] {
        RX_HUNT,
        RX_SUB,
        RX_BODY,
        RX_SKIP,
        RX_CHECK
    } rx_state_e;

endpackage

// File: rtl/tsip_packet_rx_if.sv
// Byte stream in, packet/error reports out.
// master drives the byte stream, slave is the receiver.
interface tsip_packet_rx_if #(
    parameter int MAX_LEN = 32
);
    logic                   i_rx_dv;
    logic [7:0]             i_rx_byte;
    logic                   o_pkt_dv;
    logic [7:0]             o_pkt_len;
    logic [8*MAX_LEN-1:0]   o_payload;
    logic                   o_err_dv;
    logic [1:0]             o_err_code;
    logic                   o_busy;

    modport master (
        output i_rx_dv, i_rx_byte,
        input  o_pkt_dv, o_pkt_len, o_payload,
        input  o_err_dv, o_err_code, o_busy
    );

    modport slave (
        input  i_rx_dv, i_rx_byte,
        output o_pkt_dv, o_pkt_len, o_payload,
        output o_err_dv, o_err_code, o_busy
    );
endinterface

// File: rtl/tsip_packet_rx_destuff.sv
// DLE/ETX framing and stuffing removal; emits frame start
// (ID byte), de-stuffed data, end of frame and framing error.
module tsip_destuff
    import tsip_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       abort_i,
    input  logic       rx_dv_i,
    input  logic [7:0] rx_byte_i,
    output logic       data_dv_o,
    output logic [7:0] data_byte_o,
    output logic       sof_o,
    output logic       eof_o,
    output logic       ferr_o,
    output logic       busy_o
);

    ds_state_e st_q, st_d;
    logic      dv;
    logic      is_dle;
    logic      is_etx;

    assign dv          = rx_dv_i && !abort_i;
    assign is_dle      = rx_byte_i == TSIP_DLE;
    assign is_etx      = rx_byte_i == TSIP_ETX;
    assign data_byte_o = rx_byte_i;
    assign busy_o      = st_q != DS_HUNT;

    always_ff @(posedge clk_i) begin
        if (rst_i) st_q <= DS_HUNT;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d      = st_q;
        data_dv_o = 1'b0;
        sof_o     = 1'b0;
        eof_o     = 1'b0;
        ferr_o    = 1'b0;
        if (abort_i) begin
            st_d = DS_HUNT;
        end else if (dv) begin
            unique case (st_q)
                DS_HUNT: if (is_dle) st_d = DS_START;
                DS_START: begin
                    if (is_dle || is_etx) begin
                        st_d = DS_HUNT;
                    end else begin
                        sof_o = 1'b1;
                        st_d  = DS_DATA;
                    end
                end
                DS_DATA: begin
                    if (is_dle) st_d = DS_DLE;
                    else        data_dv_o = 1'b1;
                end
                DS_DLE: begin
                    unique case (1'b1)
                        is_dle: begin
                            data_dv_o = 1'b1;
                            st_d      = DS_DATA;
                        end
                        is_etx: begin
                            eof_o = 1'b1;
                            st_d  = DS_HUNT;
                        end
                        // lone DLE: the byte opens a new frame
                        default: begin
                            ferr_o = 1'b1;
                            sof_o  = 1'b1;
                            st_d   = DS_DATA;
                        end
                    endcase
                end
                default: st_d = DS_HUNT;
            endcase
        end
    end

endmodule

// File: rtl/tsip_packet_rx.sv
// TSIP packet receiver: ID/subcode filter, payload buffer,
// length/overflow/timeout checks and a good-frame hold register.
module tsip_packet_rx
    import tsip_pkg::*;
#(
    parameter logic [7:0] MATCH_ID     = TSIP_ID_8F,
    parameter logic [7:0] MATCH_SUB    = TSIP_SUB_AB,
    parameter bit         USE_SUB      = 1'b1,
    parameter int         MAX_LEN      = 32,
    parameter int         EXP_LEN      = 17,
    parameter int         TIMEOUT_CLKS = 20840
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    tsip_packet_rx_if.slave  bus
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS);

    logic       ds_dv, ds_sof, ds_eof, ds_ferr, ds_busy;
    logic [7:0] ds_byte;

    rx_state_e            st_q, st_d;
    logic [CW-1:0]        cnt_q, cnt_d, len_q, len_d;
    logic [TW-1:0]        to_q, to_d;
    logic [7:0]           buf_q [MAX_LEN];
    logic [8*MAX_LEN-1:0] pay_q, pay_d;
    logic                 pkt_dv_q, pkt_dv_d;
    logic                 err_dv_q, err_dv_d;
    logic [1:0]           err_q, err_d;
    logic                 wr, busy, tmo;

    assign busy = ds_busy || (st_q != RX_HUNT);
    assign tmo  = busy && !bus.i_rx_dv && (to_q == TO_MAX);

    tsip_destuff u_destuff (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .abort_i     (!i_enable || tmo),
        .rx_dv_i     (bus.i_rx_dv),
        .rx_byte_i   (bus.i_rx_byte),
        .data_dv_o   (ds_dv),
        .data_byte_o (ds_byte),
        .sof_o       (ds_sof),
        .eof_o       (ds_eof),
        .ferr_o      (ds_ferr),
        .busy_o      (ds_busy)
    );

    always_comb begin
        if (!i_enable || !busy || bus.i_rx_dv) to_d = '0;
        else if (to_q != TO_MAX)               to_d = to_q + 1'b1;
        else                                   to_d = to_q;
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pay_d    = pay_q;
        pkt_dv_d = 1'b0;
        err_dv_d = 1'b0;
        err_d    = err_q;
        wr       = 1'b0;
        if (!i_enable) begin
            st_d  = RX_HUNT;
            cnt_d = '0;
        end else if (tmo) begin
            err_dv_d = 1'b1;
            err_d    = ERR_TIMEOUT;
            st_d     = RX_HUNT;
        end else begin
            unique case (st_q)
                RX_SUB: begin
                    if (ds_ferr || ds_eof) begin
                        err_dv_d = 1'b1;
                        err_d    = ERR_FRAME;
                        st_d     = RX_HUNT;
                    end else if (ds_dv) begin
                        st_d = (ds_byte == MATCH_SUB) ? RX_BODY : RX_SKIP;
                    end
                end
                RX_BODY: begin
                    if (ds_ferr) begin
                        err_dv_d = 1'b1;
                        err_d    = ERR_FRAME;
                        st_d     = RX_HUNT;
                    end else if (ds_eof) begin
                        st_d = RX_CHECK;
                    end else if (ds_dv) begin
                        if (32'(cnt_q) == MAX_LEN) begin
                            err_dv_d = 1'b1;
                            err_d    = ERR_OVF;
                            st_d     = RX_SKIP;
                        end else begin
                            wr    = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RX_SKIP: if (ds_eof) st_d = RX_HUNT;
                RX_CHECK: begin
                    if (cnt_q == '0 ||
                        (EXP_LEN != 0 && 32'(cnt_q) != EXP_LEN)) begin
                        err_dv_d = 1'b1;
                        err_d    = ERR_LEN;
                    end else begin
                        for (int i = 0; i < MAX_LEN; i++)
                            pay_d[8*i+:8] = (i < 32'(cnt_q)) ? buf_q[i] : 8'h00;
                        len_d    = cnt_q;
                        pkt_dv_d = 1'b1;
                    end
                    st_d = RX_HUNT;
                end
                default: ;
            endcase
            // ID byte, including the one that follows a lone DLE
            if (ds_sof && st_q != RX_CHECK) begin
                cnt_d = '0;
                if (ds_byte != MATCH_ID) st_d = RX_SKIP;
                else if (USE_SUB)        st_d = RX_SUB;
                else                     st_d = RX_BODY;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < MAX_LEN; i++)
            if (wr && 32'(cnt_q) == i) buf_q[i] <= ds_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q     <= RX_HUNT;
            cnt_q    <= '0;
            len_q    <= '0;
            to_q     <= '0;
            pay_q    <= '0;
            pkt_dv_q <= 1'b0;
            err_dv_q <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            to_q     <= to_d;
            pay_q    <= pay_d;
            pkt_dv_q <= pkt_dv_d;
            err_dv_q <= err_dv_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_pkt_dv   = pkt_dv_q;
    assign bus.o_pkt_len  = 8'(len_q);
    assign bus.o_payload  = pay_q;
    assign bus.o_err_dv   = err_dv_q;
    assign bus.o_err_code = err_q;
    assign bus.o_busy     = busy;

endmodule
